// File: rtl/simplez_uart_io.sv
// Simplez memory-mapped console: four I/O registers at BASE..BASE+3
// backed by one 8N1 UART (screen = transmitter, keyboard = receiver).
module simplez_uart_io #(
    parameter int DATAW    = 12,
    parameter int ADDRW    = 9,
    parameter int BASE     = 508,
    parameter int BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             sel,
    output logic             tx,
    input  logic             rx
);

    // BAUD_DIV must be at least 4 so the half-bit delay is non-zero.
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [ADDRW:0] A_LO = (ADDRW + 1)'(BASE);
    localparam logic [ADDRW:0] A_HI = (ADDRW + 1)'(BASE + 4);

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    tx_state_t      r_tx_state;
    logic [CW-1:0]  r_tx_cnt;
    logic [2:0]     r_tx_bit;
    logic           r_tx;
    logic           r_tx_ready;
    logic [7:0]     r_tx_data;

    rx_state_t      r_rx_state;
    logic [CW-1:0]  r_rx_cnt;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic [7:0]     r_rx_data;
    logic           r_rx_avail;
    logic           r_frame_err;
    logic           r_overrun;
    logic           r_rx_s1;
    logic           r_rx_s2;
    logic           r_rx_prev;

    logic [ADDRW-1:0] w_diff;
    logic [1:0]       w_off;
    logic             w_sel;
    logic             w_wr1;
    logic             w_rd2;
    logic             w_rd3;
    logic             w_tx_tick;
    logic             w_tx_done;
    logic             w_tx_accept;
    logic [2:0]       w_tx_nbit;
    logic             w_rx_tick;
    logic             w_rx_fall;
    logic             w_unused;

    // Address decode and strobe qualification.
    assign w_sel  = ({1'b0, addr} >= A_LO) && ({1'b0, addr} < A_HI);
    assign w_diff = addr - A_LO[ADDRW-1:0];
    assign w_off  = w_diff[1:0];
    assign w_wr1  = w_sel && wr && (w_off == 2'd1);
    assign w_rd2  = w_sel && rd && (w_off == 2'd2);
    assign w_rd3  = w_sel && rd && (w_off == 2'd3);
    assign sel    = w_sel;
    assign tx     = r_tx;

    assign w_unused = ^{data_in[DATAW-1:8], w_diff[ADDRW-1:2]};

    // A write on the edge that ends the stop bit is taken
    // back-to-back, so the line never idles between frames.
    assign w_tx_tick   = (r_tx_cnt == LAST);
    assign w_tx_done   = (r_tx_state == T_STOP) && w_tx_tick;
    assign w_tx_accept = w_wr1 && (r_tx_ready || w_tx_done);
    assign w_tx_nbit   = r_tx_bit + 3'd1;

    assign w_rx_tick = (r_rx_cnt == LAST);
    assign w_rx_fall = r_rx_prev && !r_rx_s2;

    // Zero-latency register read, zero-extended to the bus width.
    always_comb begin
        data_out = '0;
        if (w_sel) begin
            unique case (w_off)
                2'd0: data_out = {{(DATAW-1){1'b0}}, r_tx_ready};
                2'd1: data_out = {{(DATAW-8){1'b0}}, r_tx_data};
                2'd2: data_out = {{(DATAW-3){1'b0}},
                                  r_overrun, r_frame_err, r_rx_avail};
                2'd3: data_out = {{(DATAW-8){1'b0}}, r_rx_data};
            endcase
        end
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_data  <= '0;
        end else if (w_tx_accept) begin
            r_tx_state <= T_START;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_data  <= data_in[7:0];
        end else begin
            unique case (r_tx_state)
                T_IDLE: begin
                    r_tx_cnt <= '0;
                end
                T_START: begin
                    if (w_tx_tick) begin
                        r_tx_state <= T_DATA;
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_data[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= T_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit <= w_tx_nbit;
                            r_tx     <= r_tx_data[w_tx_nbit];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_state <= T_IDLE;
                        r_tx_cnt   <= '0;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous rx line, plus a
    // delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Receiver FSM and status flags. Read clears come first so a
    // completion on the same edge wins over the clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_state  <= R_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_avail  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_rd3) begin
                r_rx_avail <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_rd2) begin
                r_frame_err <= 1'b0;
            end
            unique case (r_rx_state)
                R_IDLE: begin
                    r_rx_cnt <= '0;
                    if (w_rx_fall) begin
                        r_rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_rx_cnt == HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= R_IDLE;
                        if (r_rx_s2) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_avail <= 1'b1;
                            if (r_rx_avail && !w_rd3) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/simplez_uart_io.md
Name: simplez_uart_io

Overview:
- Memory-mapped I/O stage directly downstream of the Simplez core's address/data buses.
- Implements the four Simplez peripheral registers as a serial console on one 8N1 UART:
  - screen status and screen data map to the UART transmitter.
  - keyboard status and keyboard data map to the UART receiver.
- The core routes busD from data_out whenever sel and rd are both high.

Parameters:
- DATAW, 12: data bus width.
- ADDRW, 9: address bus width.
- BASE, 508: address of the first I/O register; the block decodes BASE..BASE+3.
- BAUD_DIV, 104: clocks per serial bit (12 MHz / 115200). Must be at least 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- addr  in  ADDRW  address bus (RA).
- rd  in  1  read strobe (lec).
- wr  in  1  write strobe (esc).
- data_in  in  DATAW  data bus from the core.
- data_out  out  DATAW  read data, combinational.
- sel  out  1  combinational; 1 when addr is in BASE..BASE+3.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.

Behaviour:
- Register map (offset from BASE):
  - +0 screen status: bit0 = tx_ready. Read-only.
  - +1 screen data: write sends data_in[7:0]. Read returns the last accepted byte.
  - +2 keyboard status: bit0 = rx_avail, bit1 = frame_err, bit2 = overrun.
  - +3 keyboard data: read returns the rx byte.
- Read path:
  - data_out is zero-latency (combinational) and zero-extended to DATAW.
  - data_out = 0 when sel = 0.
- Write and read side effects:
  - Writes to +0, +2 and +3 are ignored.
  - A write to +1 while tx_ready = 0 is dropped; no queueing.
  - Side effects occur on the rising edge where the strobe is high and the address matches.
  - Reading +3 clears rx_avail and overrun.
  - Reading +2 clears frame_err.
- Reset values (rstn low at an edge): tx = 1, tx_ready = 1, rx_avail = 0, frame_err = 0, overrun = 0, tx/rx data registers = 0, both FSMs idle.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on that edge.
- TX FSM, states T_IDLE, T_START, T_DATA, T_STOP:
  - An accepted write at edge N drives tx = 0 and tx_ready = 0 from edge N onward.
  - Each bit lasts BAUD_DIV cycles. Data bits are sent LSB first, then a stop bit of 1.
  - tx_ready returns to 1 exactly 10*BAUD_DIV cycles after edge N. A write on that same edge is accepted.
- RX synchroniser: rx passes through 2 flip-flops before any use.
- RX FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - In R_IDLE, a synced falling edge starts the frame.
  - After BAUD_DIV/2 cycles, rx is re-checked. If it is still 0, continue; otherwise return to R_IDLE (glitch rejected, no flags set).
  - The 8 data bits and the stop bit are sampled every BAUD_DIV cycles after that.
  - Stop bit = 1: load the data register and set rx_avail.
    - If rx_avail was already 1 (not read this edge), also set overrun; the new byte overwrites the old.
  - Stop bit = 0: discard the byte and set frame_err.
  - After the stop sample, the FSM waits for rx = 1 before re-arming.
- Simultaneous events:
  - Byte completion on the same edge as a read of +3: the new byte is loaded, rx_avail stays 1, overrun = 0.
  - Frame error on the same edge as a read of +2: frame_err stays 1.
- Counters:
  - The baud counter is ceil(log2(BAUD_DIV)) bits wide and wraps to 0 at BAUD_DIV-1.
  - The bit counter is 3 bits wide.
  - TX and RX keep independent counters.

Test Plan (BAUD_DIV = 4):
1. Hold rstn = 0 for 2 cycles, then release -> tx = 1; read 508 gives 0x001; read 510 gives 0x000; read 100 gives data_out = 0 and sel = 0.
2. Write 0xA55 to 509 -> tx waveform is 0, 1,0,1,0,1,0,1,0 (0x55 LSB first), 1, 4 cycles per bit; 508 reads 0x000 during the frame and 0x001 exactly 40 cycles after the write; 509 reads 0x055.
3. Write 0x041 to 509, then write 0x042 at cycle 5 -> only 0x41 appears on tx; 509 reads 0x041.
4. Drive a 0xC3 frame on rx -> 510 reads 0x001 and 511 reads 0x0C3; the next read of 510 gives 0x000.
5. Drive two frames 0x11 then 0x22 without reading -> 510 = 0x005 and 511 = 0x022; afterwards 510 = 0x000. Drive a frame with stop bit 0 -> 510 = 0x002, and reading 510 clears it.
6. Pull rx low for 1 cycle -> no flags set. Assert rstn low at cycle 15 of a tx frame -> tx = 1 and 508 = 0x001 on the next cycle.
